unidad_muldiv: RTL and testbench
================================

Name: unidad_muldiv

Overview:
- Parametrised iterative multiply/divide unit for the segmented processor's execute stage.
- Adds MULT/MULTU/DIV/DIVU with architectural HI/LO registers and a start/busy/done handshake.
- The hazard logic stalls dependent instructions while oBusy is high.
- Replaces single-cycle ALU-only arithmetic with a WIDTH-generic multi-cycle datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be even and at least 4. HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- iStart  input  1  start request; accepted only when oBusy=0.
- iOp  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- iA  input  WIDTH  multiplicand / dividend.
- iB  input  WIDTH  multiplier / divisor.
- iMtHi  input  1  write iMtData into HI (MTHI).
- iMtLo  input  1  write iMtData into LO (MTLO).
- iMtData  input  WIDTH  data for MTHI/MTLO.
- oBusy  output  1  operation in progress.
- oDone  output  1  one-cycle pulse; HI/LO hold the new result.
- oHi  output  WIDTH  HI register.
- oLo  output  WIDTH  LO register.
- oDivZero  output  1  last accepted operation was a divide by zero.

Behaviour:
- Clock and reset: one clock domain (clk). Reset is synchronous and active-high (reset).
- Reset values: state=IDLE, oBusy=0, oDone=0, oDivZero=0, oHi=0, oLo=0, iteration counter=0.
- Reset mid-operation aborts the operation: no oDone, HI/LO cleared.
- State machine has two states, IDLE and CALC.
- IDLE behaviour:
  - iStart=1 latches the operands and iOp and clears oDivZero.
  - Signed ops latch magnitudes plus sign flags.
  - Next state is CALC with counter=0.
  - Exception: DIV/DIVU with iB=0 stays in IDLE. On that edge HI=iA, LO=all ones, oDivZero=1, and oDone=1 in the following cycle.
- CALC behaviour:
  - One radix-2 iteration per edge; counter increments.
  - Multiply: shift-add on magnitudes.
  - Divide: restoring shift-subtract on magnitudes.
  - The edge with counter=WIDTH-1 completes the operation: it writes HI/LO, returns to IDLE, and oDone=1 in the following cycle.
- Latency: accept edge T. oBusy=1 for cycles T+1 .. T+WIDTH. oDone=1 and oBusy=0 in cycle T+WIDTH+1.
- Back-to-back: a new iStart is accepted in the oDone cycle.
- Multiply result: 2*WIDTH-bit product, HI = upper half, LO = lower half.
  - MULT negates the full product when the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - DIV truncates toward zero. Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Most-negative / -1 gives LO = 1 followed by WIDTH-1 zeros, HI=0. No overflow flag.
- oHi/oLo hold their old values throughout CALC. Partial results live in internal registers only.
- MTHI/MTLO:
  - When oBusy=0 and iStart=0, iMtHi/iMtLo write HI/LO on that edge. Both may be set in the same cycle.
  - Ignored while oBusy=1.
  - If iStart=1 in the same cycle, the start wins and the writes are ignored.
- iStart while oBusy=1 is ignored; the operation in flight is unaffected.
- oDivZero is sticky until the next accepted iStart or reset.

Test Plan (WIDTH=32):
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> oBusy high 32 cycles; oDone in cycle 33 after accept; HI=0xFFFFFFFE, LO=0x00000001.
- MULT -3*7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then MULT 0x80000000*0x80000000 -> HI=0x40000000, LO=0.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU 5/0 -> no busy; oDone next cycle; oDivZero=1, HI=5, LO=0xFFFFFFFF. A following MULTU clears oDivZero.
- Busy-period inputs: during MULTU, iStart and iMtHi with 0xAAAA are ignored; HI/LO equal the MULTU result. In IDLE, iMtLo=1 with 0x1234 -> oLo=0x1234 next cycle.
- Reset and handshake: reset during cycle 10 of DIVU -> next cycle oBusy=0, oHi=oLo=0, no oDone; a subsequent DIVU 9/4 gives LO=2, HI=1. A start issued in the oDone cycle is accepted with correct timing.

Source files
------------

// File: rtl/unidad_muldiv.sv
// unidad_muldiv: iterative radix-2 multiply/divide unit with architectural HI/LO.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous active-high reset
//   iStart    start request, accepted only while idle
//   iOp       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   iA, iB    multiplicand/dividend, multiplier/divisor
//   iMtHi/Lo  write iMtData into HI/LO while idle and not starting
//   oBusy     operation in progress
//   oDone     one-cycle pulse, HI/LO hold the new result
//   oHi, oLo  architectural HI/LO registers
//   oDivZero  last accepted operation was a divide by zero (sticky)
//
// Signed operations run on magnitudes; signs are reapplied on the final edge.
module unidad_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic             iMtHi,
    input  logic             iMtLo,
    input  logic [WIDTH-1:0] iMtData,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oHi,
    output logic [WIDTH-1:0] oLo,
    output logic             oDivZero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {StIdle, StCalc} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic             op_div_q;   // iOp[1] of the operation in flight
    logic             neg_q;      // product / quotient sign
    logic             neg_rem_q;  // remainder sign (dividend sign)
    // Mult: acc_hi = partial product high, acc_lo = multiplier (shifts out), opb = multiplicand.
    // Div:  acc_hi = partial remainder, acc_lo = dividend -> quotient, opb = divisor.
    logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opb_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ok;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fin_hi, fin_lo;

    always_comb begin
        a_neg = ~iOp[0] & iA[WIDTH-1];
        b_neg = ~iOp[0] & iB[WIDTH-1];
        a_mag = a_neg ? -iA : iA;
        b_mag = b_neg ? -iB : iB;

        // Shift-add: add multiplicand into the high half when the multiplier LSB is set.
        mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : '0);

        // Restoring divide: shifted remainder can exceed WIDTH bits, so compare at WIDTH+1.
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_ok    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift - {1'b0, opb_q};

        if (op_div_q) begin
            step_hi = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
            step_lo = {acc_lo_q[WIDTH-2:0], div_ok};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
        end

        prod = {step_hi, step_lo};
        if (op_div_q) begin
            fin_lo = neg_q ? -step_lo : step_lo;
            fin_hi = neg_rem_q ? -step_hi : step_hi;
        end else begin
            if (neg_q) prod = -prod;
            fin_hi = prod[2*WIDTH-1:WIDTH];
            fin_lo = prod[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            op_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
            oHi       <= '0;
            oLo       <= '0;
            oDivZero  <= 1'b0;
        end else begin
            oDone <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (iStart) begin
                        oDivZero <= 1'b0;
                        op_div_q <= iOp[1];
                        if (iOp[1] && iB == '0) begin
                            // Divide by zero completes immediately without going busy.
                            oHi      <= iA;
                            oLo      <= '1;
                            oDivZero <= 1'b1;
                            oDone    <= 1'b1;
                        end else begin
                            neg_q     <= a_neg ^ b_neg;
                            neg_rem_q <= a_neg;
                            acc_hi_q  <= '0;
                            acc_lo_q  <= iOp[1] ? a_mag : b_mag;
                            opb_q     <= iOp[1] ? b_mag : a_mag;
                            cnt_q     <= '0;
                            oBusy     <= 1'b1;
                            state_q   <= StCalc;
                        end
                    end else begin
                        if (iMtHi) oHi <= iMtData;
                        if (iMtLo) oLo <= iMtData;
                    end
                end
                StCalc: begin
                    acc_hi_q <= step_hi;
                    acc_lo_q <= step_lo;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        oHi     <= fin_hi;
                        oLo     <= fin_lo;
                        oDone   <= 1'b1;
                        oBusy   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_unidad_muldiv.sv
module tb_unidad_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        iStart;
    logic [1:0]  iOp;
    logic [31:0] iA, iB;
    logic        iMtHi, iMtLo;
    logic [31:0] iMtData;
    logic        oBusy, oDone, oDivZero;
    logic [31:0] oHi, oLo;

    unidad_muldiv #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .iStart   (iStart),
        .iOp      (iOp),
        .iA       (iA),
        .iB       (iB),
        .iMtHi    (iMtHi),
        .iMtLo    (iMtLo),
        .iMtData  (iMtData),
        .oBusy    (oBusy),
        .oDone    (oDone),
        .oHi      (oHi),
        .oLo      (oLo),
        .oDivZero (oDivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: every oDone pops one expected result.
    always @(negedge clk) begin
        if (oDone) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got oDone=1, expected no result pending");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_hi", {32'h0, oHi}, {32'h0, e.hi});
                chk("result_lo", {32'h0, oLo}, {32'h0, e.lo});
                chk("result_divzero", {63'h0, oDivZero}, {63'h0, e.dz});
            end
        end
    end

    // Issues one operation and checks busy length / done timing. Returns at the
    // falling edge of the oDone cycle. now=1 asserts iStart in the current cycle.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input logic dz,
                         input int exp_busy, input bit now, input bit inject, input bit mt);
        exp_t e;
        int   cycles = 0;
        int   busy_cnt = 0;
        e.hi = hi; e.lo = lo; e.dz = dz;
        sb.push_back(e);
        if (!now) @(negedge clk);
        iStart = 1'b1; iOp = op; iA = a; iB = b;
        iMtHi = mt; iMtData = 32'h5555;
        @(negedge clk);
        iStart = 1'b0; iMtHi = 1'b0; iA = '0; iB = '0;
        while (!oDone && cycles < 100) begin
            if (oBusy) busy_cnt++;
            if (inject && cycles == 5) begin
                iStart = 1'b1; iOp = DIVU; iA = 32'h1; iB = 32'h0;
                iMtHi = 1'b1; iMtData = 32'hAAAA;
            end else begin
                iStart = 1'b0; iMtHi = 1'b0;
            end
            @(negedge clk);
            cycles++;
        end
        iStart = 1'b0; iMtHi = 1'b0;
        chk("done_latency", 64'(cycles), 64'(exp_busy));
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        chk("busy_low_at_done", {63'h0, oBusy}, 64'h0);
    endtask

    initial begin
        int dones;
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        reset = 1'b1; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
        iMtHi = 1'b0; iMtLo = 1'b0; iMtData = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", {63'h0, oBusy}, 64'h0);
        chk("reset_done", {63'h0, oDone}, 64'h0);
        chk("reset_divzero", {63'h0, oDivZero}, 64'h0);
        chk("reset_hilo", {oHi, oLo}, 64'h0);
        reset = 1'b0;

        do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 32, 0, 0, 0);
        do_op(MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 0, 32, 0, 0, 0);
        do_op(MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 32, 0, 0, 0);
        do_op(MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 0, 32, 0, 0, 0);
        do_op(DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 0, 32, 0, 0, 0);
        do_op(DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 32, 0, 0, 0);
        do_op(DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       0, 32, 0, 0, 0);
        do_op(DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0, 32, 0, 0, 0);

        // Divide by zero: no busy period, sticky flag.
        do_op(DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("divzero_sticky", {63'h0, oDivZero}, 64'h1);
        chk("divzero_hold_hi", {32'h0, oHi}, 64'd5);

        // Busy-period iStart and MTHI are ignored; this start also clears oDivZero.
        do_op(MULTU, 32'd3,        32'd5,        32'd0,        32'd15,       0, 32, 0, 1, 0);
        repeat (2) @(negedge clk);
        chk("busy_mthi_ignored", {32'h0, oHi}, 64'd0);

        // MTLO in idle, then MTHI+MTLO together.
        iMtLo = 1'b1; iMtData = 32'h1234;
        @(negedge clk);
        iMtLo = 1'b0;
        chk("mtlo_lo", {32'h0, oLo}, 64'h1234);
        chk("mtlo_hi_kept", {32'h0, oHi}, 64'h0);
        iMtHi = 1'b1; iMtLo = 1'b1; iMtData = 32'hCAFE0001;
        @(negedge clk);
        iMtHi = 1'b0; iMtLo = 1'b0;
        chk("mt_both", {oHi, oLo}, 64'hCAFE0001_CAFE0001);

        // Start wins over a simultaneous MTHI.
        do_op(MULTU, 32'd6,        32'd7,        32'd0,        32'd42,       0, 32, 0, 0, 1);

        // Reset during cycle 10 of a DIVU.
        do_op(MULTU, 32'h10000,    32'h10003,    32'd1,        32'h30000,    0, 32, 0, 0, 0);
        @(negedge clk);
        iStart = 1'b1; iOp = DIVU; iA = 32'd100; iB = 32'd7;
        @(negedge clk);
        iStart = 1'b0;
        repeat (9) @(negedge clk);
        chk("busy_before_reset", {63'h0, oBusy}, 64'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {63'h0, oBusy}, 64'h0);
        chk("abort_done", {63'h0, oDone}, 64'h0);
        chk("abort_hilo", {oHi, oLo}, 64'h0);
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (oDone) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'h0);

        do_op(DIVU,  32'd9,        32'd4,        32'd1,        32'd2,        0, 32, 0, 0, 0);
        // Back-to-back: start asserted in the oDone cycle.
        do_op(MULTU, 32'd6,        32'd9,        32'd0,        32'd54,       0, 32, 1, 0, 0);
        do_op(DIVU,  32'd77,       32'd0,        32'd77,       32'hFFFFFFFF, 1, 0, 1, 0, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
